// File: rtl/uart_loader.sv
// uart_loader: host serial download endpoint.
// Receives 8N1 UART bytes and parses the command 'S' (0x53), a 4-byte LE
// address, a 4-byte LE length, then that many payload bytes. Each payload byte
// is issued as a single-beat byte write on the mem_* request port.
//
// Optional feature macro: UART_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the payload. It must equal the XOR of
//   all payload bytes; a mismatch sets the sticky err_csum flag. When the macro
//   is undefined, err_csum is tied low.
//
// Ports:
//   g_clk, g_resetn      clock, async active-low reset
//   uart_rxd             serial input (idle high, asynchronous)
//   mem_req / mem_gnt    write request valid / accepted this cycle
//   mem_addr             word-aligned byte address
//   mem_wdata            payload byte replicated into all four lanes
//   mem_strb             one-hot byte strobe for addr[1:0]
//   busy                 load in progress ('S' accepted, final write pending)
//   done                 one-cycle pulse when a load completes
//   err_frame            sticky: stop bit sampled low
//   err_overrun          sticky: byte arrived while a write was pending
//   err_csum             sticky: payload checksum mismatch (feature build only)
module uart_loader #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 115200
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        uart_rxd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  output logic        busy,
  output logic        done,
  output logic        err_frame,
  output logic        err_overrun,
  output logic        err_csum
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW             = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state;
  logic          rxd_s1, rxd_s2, rxd_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic          rx_fall;

  // rxd_d is the edge register behind the synchroniser
  assign rx_fall = rxd_d & ~rxd_s2;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      rxd_d     <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_d    <= rxd_s2;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_fall) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        // Mid-point of the start bit; a high line here was a glitch
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rxd_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
          if (rxd_s2) rx_valid  <= 1'b1;
          else        err_frame <= 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ parser
  typedef enum logic [2:0] {
    P_IDLE, P_ADDR, P_LEN, P_DATA, P_WRITE
`ifdef UART_LOADER_CHECKSUM_EN
    , P_CSUM
`endif
  } p_state_t;

  p_state_t    p_state;
  logic [31:0] addr, len;
  logic [1:0]  bcnt;
  logic [31:0] len_full;

  // Multi-byte fields shift in from the top so the first byte lands in [7:0]
  assign len_full = {rx_shift, len[31:8]};

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`else
  assign err_csum = 1'b0;
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      p_state     <= P_IDLE;
      addr        <= '0;
      len         <= '0;
      bcnt        <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_strb    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum        <= '0;
      err_csum    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (p_state)
        P_IDLE: if (rx_valid && rx_shift == 8'h53) begin
          busy    <= 1'b1;
          bcnt    <= '0;
          p_state <= P_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
          csum    <= '0;
`endif
        end
        P_ADDR: if (rx_valid) begin
          addr <= {rx_shift, addr[31:8]};
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) p_state <= P_LEN;
        end
        P_LEN: if (rx_valid) begin
          len  <= len_full;
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            if (len_full == '0) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              p_state <= P_IDLE;
            end else p_state <= P_DATA;
          end
        end
        P_DATA: if (rx_valid) begin
          mem_req   <= 1'b1;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_wdata <= {4{rx_shift}};
          mem_strb  <= 4'b0001 << addr[1:0];
          p_state   <= P_WRITE;
`ifdef UART_LOADER_CHECKSUM_EN
          csum      <= csum ^ rx_shift;
`endif
        end
        // Request fields stay frozen here; a byte arriving now is lost
        P_WRITE: begin
          if (rx_valid) err_overrun <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            addr    <= addr + 32'd1;
            len     <= len - 32'd1;
            if (len == 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
              p_state <= P_CSUM;
`else
              done    <= 1'b1;
              busy    <= 1'b0;
              p_state <= P_IDLE;
`endif
            end else p_state <= P_DATA;
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        P_CSUM: if (rx_valid) begin
          if (rx_shift != csum) err_csum <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          p_state <= P_IDLE;
        end
`endif
        default: p_state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader. A byte-level model turns each command into
// the list of writes (word address, replicated data, one-hot strobe) and the
// number of done pulses it must produce; a single compare process checks every
// fired write and the hold-stable rule against that model.
module tb_uart_loader;
  localparam int CLK_HZ   = 1_600_000;
  localparam int BIT_RATE = 100_000;
  localparam int CPB      = CLK_HZ / BIT_RATE;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        mem_gnt = 1'b1;
  logic        mem_req, busy, done, err_frame, err_overrun, err_csum;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_strb;

  uart_loader #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .uart_rxd(uart_rxd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .busy(busy), .done(done),
    .err_frame(err_frame), .err_overrun(err_overrun), .err_csum(err_csum)
  );

  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } w_t;

  w_t exp_q[$];
  w_t wlog[$];
  w_t e, p_w;
  logic p_req = 1'b0, p_gnt = 1'b0;
  int tests = 0, fails = 0, done_cnt = 0, exp_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge g_clk); #1; end
  endtask

  // Model: byte b destined for byte address a
  task automatic expect_write(input logic [31:0] a, input logic [7:0] b);
    w_t w;
    w.addr  = a & 32'hFFFF_FFFC;
    w.wdata = {b, b, b, b};
    w.strb  = 4'(1 << a[1:0]);
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    uart_rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; tick(CPB); end
    uart_rxd = stop_ok; tick(CPB);
    if (!stop_ok) begin uart_rxd = 1'b1; tick(CPB); end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    chk1("busy_timeout", busy, 1'b0);
  endtask

  // Compare process
  always @(negedge g_clk) begin
    if (!g_resetn) begin
      p_req = 1'b0;
    end else begin
      if (p_req && !p_gnt) begin
        chk1("req_held", mem_req, 1'b1);
        chk("addr_held", mem_addr, p_w.addr);
        chk("wdata_held", mem_wdata, p_w.wdata);
        chk("strb_held", {28'd0, mem_strb}, {28'd0, p_w.strb});
      end
      if (mem_req && mem_gnt) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %h wdata %h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_wdata", mem_wdata, e.wdata);
          chk("wr_strb", {28'd0, mem_strb}, {28'd0, e.strb});
        end
        wlog.push_back('{mem_addr, mem_wdata, mem_strb});
      end
      if (done) done_cnt++;
      p_req = mem_req;
      p_gnt = mem_gnt;
      p_w   = '{mem_addr, mem_wdata, mem_strb};
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_strb"}, {28'd0, mem_strb}, 32'd0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err_frame"}, err_frame, 1'b0);
    chk1({tag, "_err_overrun"}, err_overrun, 1'b0);
    chk1({tag, "_err_csum"}, err_csum, 1'b0);
  endtask

  initial begin
    int w0, d0;
    tick(3);
    chk_reset_vals("rst");
    g_resetn = 1'b1;
    tick(200);

    // 'S' alone: busy, nothing else
    send_byte(8'h53);
    tick(5);
    chk1("s_busy", busy, 1'b1);
    chk1("s_no_req", mem_req, 1'b0);
    chk1("s_err_frame", err_frame, 1'b0);
    chk1("s_err_overrun", err_overrun, 1'b0);

    // Rest of the command: addr 0, len 256, payload 0x00..0xFF
    send_word(32'h0000_0000);
    send_word(32'h0000_0100);
    w0 = wlog.size();
    for (int i = 0; i < 256; i++) begin
      expect_write(32'(i), 8'(i));
      send_byte(8'(i));
    end
    exp_done++;
    wait_idle(50);
    tick(3);
    chk("big_done", done_cnt, exp_done);
    chk("big_count", wlog.size() - w0, 256);
    chk("big_w0_wdata", wlog[w0].wdata, 32'h0000_0000);
    chk("big_w1_wdata", wlog[w0+1].wdata, 32'h0101_0101);
    chk("big_w1_strb", {28'd0, wlog[w0+1].strb}, 32'd2);
    chk("big_last_addr", wlog[w0+255].addr, 32'h0000_00FC);
    chk("big_last_strb", {28'd0, wlog[w0+255].strb}, 32'd8);

    // Wrap test with a bad frame injected between address bytes
    send_byte(8'h53);
    send_byte(8'hFE);
    send_byte(8'h77, 1'b0);
    chk1("ferr_flag", err_frame, 1'b1);
    chk1("ferr_busy", busy, 1'b1);
    chk1("ferr_no_req", mem_req, 1'b0);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    send_word(32'd3);
    w0 = wlog.size();
    for (int i = 0; i < 3; i++) begin
      expect_write(32'hFFFF_FFFE + 32'(i), 8'hA1 + 8'(i));
      send_byte(8'hA1 + 8'(i));
    end
    exp_done++;
    wait_idle(50);
    tick(3);
    chk("wrap_done", done_cnt, exp_done);
    chk("wrap_a0", wlog[w0].addr, 32'hFFFF_FFFC);
    chk("wrap_s0", {28'd0, wlog[w0].strb}, 32'd4);
    chk("wrap_a1", wlog[w0+1].addr, 32'hFFFF_FFFC);
    chk("wrap_s1", {28'd0, wlog[w0+1].strb}, 32'd8);
    chk("wrap_a2", wlog[w0+2].addr, 32'h0000_0000);
    chk("wrap_s2", {28'd0, wlog[w0+2].strb}, 32'd1);

    // Overrun: grant held low for two byte times; BB is lost
    send_byte(8'h53);
    send_word(32'h0000_0100);
    send_word(32'd2);
    mem_gnt = 1'b0;
    expect_write(32'h100, 8'hAA);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(10 * CPB);
    chk1("ovr_flag", err_overrun, 1'b1);
    chk1("ovr_req", mem_req, 1'b1);
    chk("ovr_wdata", mem_wdata, 32'hAAAA_AAAA);
    mem_gnt = 1'b1;
    expect_write(32'h101, 8'hCC);
    send_byte(8'hCC);
    exp_done++;
    wait_idle(50);
    tick(3);
    chk("ovr_done", done_cnt, exp_done);

    // Zero-length command
    d0 = done_cnt;
    send_byte(8'h53);
    send_word(32'h0000_0040);
    send_word(32'd0);
    exp_done++;
    tick(3);
    chk("len0_pulse", done_cnt - d0, 1);
    chk1("len0_busy", busy, 1'b0);

    // Reset in the middle of a pending write
    send_byte(8'h53);
    send_word(32'h0000_0200);
    send_word(32'd4);
    mem_gnt = 1'b0;
    send_byte(8'h11);
    tick(2);
    chk1("mid_req", mem_req, 1'b1);
    #2 g_resetn = 1'b0;
    #1 chk_reset_vals("midrst");
    tick(2);
    g_resetn = 1'b1;
    mem_gnt = 1'b1;
    tick(5);

    // Recovery after reset
    send_byte(8'h53);
    send_word(32'h0000_0013);
    send_word(32'd1);
    expect_write(32'h13, 8'h5A);
    send_byte(8'h5A);
    exp_done++;
    wait_idle(50);
    tick(3);
    chk("post_done", done_cnt, exp_done);
    chk("exp_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
# uart_loader

Device-side endpoint of the host serial download link. It deserialises 8N1 UART frames on `uart_rxd` and parses the load command stream: `0x53` ('S'), a 4-byte little-endian address, a 4-byte little-endian length, then that many payload bytes. Each payload byte is written to system memory through a single-beat byte-write request port. It sits between the board UART pin and the SoC memory interconnect, and holds the CPU in reset while a load is in progress.

## Interface
- `CLK_HZ`, 50_000_000, `g_clk` frequency in Hz.
- `BIT_RATE`, 115200, UART baud rate.
- `CYCLES_PER_BIT` (localparam), CLK_HZ/BIT_RATE (integer division), clock cycles per UART bit.
- `g_clk`  in  1  system clock; the only clock.
- `g_resetn`  in  1  asynchronous, active-low reset.
- `uart_rxd`  in  1  serial input, idle high, asynchronous to `g_clk`.
- `mem_req`  out  1  write request valid.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_addr`  out  32  word-aligned byte address (`addr[31:2]`, `2'b00`).
- `mem_wdata`  out  32  payload byte replicated in all four lanes.
- `mem_strb`  out  4  one-hot byte strobe, `1 << addr[1:0]`.
- `busy`  out  1  high from acceptance of 'S' until the final write is granted.
- `done`  out  1  one-cycle pulse when a load completes.
- `err_frame`  out  1  sticky: a stop bit was sampled low.
- `err_overrun`  out  1  sticky: a byte completed while a write was still pending.

## Operation
- Receiver: `uart_rxd` passes through a 2-flop synchroniser (reset value 1). The receiver FSM has states RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START on a synchronised falling edge.
  - RX_START checks the line at CYCLES_PER_BIT/2. If the line is high (glitch), it returns to RX_IDLE. Otherwise it goes to RX_DATA.
  - RX_DATA samples 8 bits, LSB first, every CYCLES_PER_BIT.
  - RX_STOP samples the stop bit. If high, it raises the internal `rx_valid` for 1 cycle with the byte. If low, it sets `err_frame` and discards the byte. Either way it returns to RX_IDLE.
- Parser FSM states: P_IDLE, P_ADDR, P_LEN, P_DATA, P_WRITE.
  - P_IDLE: byte 0x53 → P_ADDR and `busy`=1. Any other byte is ignored.
  - P_ADDR: accumulates 4 bytes LSB first into `addr`, then → P_LEN.
  - P_LEN: accumulates 4 bytes into `len`. If `len`=0, pulse `done` and → P_IDLE. Otherwise → P_DATA.
  - P_DATA: each received byte → P_WRITE with `mem_req`=1.
  - P_WRITE: `mem_req`, `mem_addr`, `mem_wdata` and `mem_strb` are held stable until `mem_gnt`. On grant: `addr`+=1 (wraps modulo 2^32), `len`-=1. If the new `len` is 0, pulse `done`, drop `busy` and → P_IDLE. Otherwise → P_DATA.
- If `rx_valid` arrives in P_WRITE, set `err_overrun` and drop the byte; the pending write continues.
- Error flags clear only on reset.
- Reset mid-load: all state, including any pending request, is abandoned immediately.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_strb`=0.
  - `busy`=0, `done`=0, `err_frame`=0, `err_overrun`=0.
  - Both FSMs in their IDLE states.
- Start-edge detection lags the pin by 2 cycles (synchroniser) plus 1 cycle (edge register).
- `rx_valid` asserts at stop-bit mid-point, 9.5×CYCLES_PER_BIT ±1 cycle after the detected edge.
- Parser reacts in the same cycle as `rx_valid`; for payload bytes, `mem_req` rises the following cycle.
- `mem_req` may not drop without `mem_gnt`. The request fires when `mem_req`&`mem_gnt` are both high in a cycle.
- `done` pulses in the cycle after the final grant, or after the fourth length byte when `len`=0.
- A grant that stalls longer than about 1 byte time (10×CYCLES_PER_BIT) causes overrun on the next byte.

## Configuration
- `UART_LOADER_CHECKSUM_EN`:
  - Defined: after the last payload grant, the parser enters P_CSUM and waits for one extra byte. If that byte ≠ the XOR of all payload bytes, it sets sticky output `err_csum`. It then pulses `done` and → P_IDLE. `busy` stays high through P_CSUM.
  - Undefined: there is no P_CSUM state, `err_csum` is tied 0 and the protocol is exactly as above.

## Test plan
- Idle line high for 1 ms, then one frame 0x53 with a correct stop bit → `busy`=1; no `mem_req`, no errors.
- Stream 53 00 00 00 00 | 00 01 00 00 | bytes 0x00..0xFF with `mem_gnt` tied 1 → 256 writes, then a `done` pulse and `busy`=0:
  - addresses 0x0..0xFC, strobes cycling 1,2,4,8;
  - `mem_wdata`=0x00000000 for the first write and 0x01010101 for the second.
- Address bytes FE FF FF FF, length 3 → writes at 0xFFFFFFFC (strb 4), 0xFFFFFFFC (strb 8), then 0x00000000 (strb 1).
- Frame with the stop bit driven low → `err_frame`=1; the byte is not consumed, and the parser state is unchanged.
- `mem_gnt` held 0 for 2 byte times during payload → `err_overrun`=1; the first write completes intact once `mem_gnt` rises.
- Length 0 command → `done` pulse after the 9th byte with no `mem_req`. Separately, assert `g_resetn`=0 mid-payload → all outputs return to their reset values immediately.
